// File: rtl/tx_frame_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_frame_arbiter_if                                          |
// | Description : AXIS bundle between NUM_PORTS frame sources, the arbiter and |
// |               the TX MAC slave port.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface tx_frame_arbiter_if #(
   parameter int NUM_PORTS       = 4,
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH/8
);
   logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_tx_tdata;
   logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] s_tx_tkeep;
   logic [NUM_PORTS-1:0]                 s_tx_tvalid;
   logic [NUM_PORTS-1:0]                 s_tx_tlast;
   logic [NUM_PORTS-1:0]                 s_tx_tready;
   logic [AXIS_DATA_WIDTH-1:0]           m_tx_tdata;
   logic [AXIS_DATA_BYTES-1:0]           m_tx_tkeep;
   logic                                 m_tx_tvalid;
   logic                                 m_tx_tlast;
   logic                                 m_tx_tready;

   // Arbiter side: sinks the sources, drives the MAC.
   modport slave (
      input  s_tx_tdata, s_tx_tkeep, s_tx_tvalid, s_tx_tlast,
      output s_tx_tready,
      output m_tx_tdata, m_tx_tkeep, m_tx_tvalid, m_tx_tlast,
      input  m_tx_tready
   );

   // Environment side: the sources plus the MAC.
   modport master (
      output s_tx_tdata, s_tx_tkeep, s_tx_tvalid, s_tx_tlast,
      input  s_tx_tready,
      input  m_tx_tdata, m_tx_tkeep, m_tx_tvalid, m_tx_tlast,
      output m_tx_tready
   );
endinterface
`default_nettype wire

// File: rtl/tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_frame_arbiter                                             |
// | Description : Frame-granular round-robin arbiter in front of the TX MAC    |
// |               AXIS slave; re-arbitrates only after a tlast handshake.      |
// |               Optional macro TX_ARB_STRICT_PRIO_EN gives port 0 strict     |
// |               priority over the round-robin ports.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tx_frame_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH/8,
   parameter int MAX_BEATS       = 380
) (
   input  logic                  tx_clk,
   input  logic                  tx_rst,
   tx_frame_arbiter_if.slave     axis,
   output logic [NUM_PORTS-1:0]  grant,
   output logic                  busy,
   output logic                  oversize_error
);
   localparam int c_IDX_W = $clog2(NUM_PORTS);
   localparam int c_CNT_W = $clog2(MAX_BEATS + 2);
   localparam logic [c_CNT_W-1:0]   c_CNT_LIMIT = c_CNT_W'(MAX_BEATS);
   localparam logic [c_CNT_W-1:0]   c_CNT_SAT   = c_CNT_W'(MAX_BEATS + 1);
   localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(NUM_PORTS - 1);
   localparam logic [c_IDX_W:0]     c_NPORTS    = (c_IDX_W+1)'(NUM_PORTS);
   localparam logic [NUM_PORTS-1:0] c_ONE       = NUM_PORTS'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PASS = 1'b1
   } state_t;

   state_t                 r_state;
   logic [NUM_PORTS-1:0]   r_grant;
   logic [c_IDX_W-1:0]     r_gidx;
   logic [c_IDX_W-1:0]     r_rr_ptr;
   logic [c_CNT_W-1:0]     r_beat_cnt;
   logic                   r_busy;

   logic [c_IDX_W:0]       w_idx;
   logic [c_IDX_W-1:0]     w_sel;
   logic [c_IDX_W-1:0]     w_next_ptr;
   logic                   w_req_any;
   logic [AXIS_DATA_WIDTH-1:0] w_tdata;
   logic [AXIS_DATA_BYTES-1:0] w_tkeep;
   logic                   w_tvalid;
   logic                   w_tlast;
   logic                   w_hs;

   // Scan from the far end of the rotation back to rr_ptr so the last hit is the nearest requester.
   always_comb begin
      w_sel = '0;
      w_idx = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
         if (w_idx >= c_NPORTS) begin
            w_idx = w_idx - c_NPORTS;
         end
`ifdef TX_ARB_STRICT_PRIO_EN
         if ((w_idx[c_IDX_W-1:0] != '0) && axis.s_tx_tvalid[w_idx[c_IDX_W-1:0]]) begin
            w_sel = w_idx[c_IDX_W-1:0];
         end
`else
         if (axis.s_tx_tvalid[w_idx[c_IDX_W-1:0]]) begin
            w_sel = w_idx[c_IDX_W-1:0];
         end
`endif
      end
`ifdef TX_ARB_STRICT_PRIO_EN
      if (axis.s_tx_tvalid[0]) begin
         w_sel = '0;
      end
`endif
   end

   assign w_req_any  = |axis.s_tx_tvalid;
   assign w_next_ptr = (r_gidx == c_LAST_IDX) ? '0 : (r_gidx + c_IDX_W'(1));

   // Grant is one-hot and all-zero in IDLE, so the mux output is quiet between frames.
   always_comb begin
      w_tdata  = '0;
      w_tkeep  = '0;
      w_tvalid = 1'b0;
      w_tlast  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (r_grant[i]) begin
            w_tdata  = axis.s_tx_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            w_tkeep  = axis.s_tx_tkeep[i*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
            w_tvalid = axis.s_tx_tvalid[i];
            w_tlast  = axis.s_tx_tlast[i];
         end
      end
   end

   assign w_hs             = w_tvalid & axis.m_tx_tready;
   assign axis.m_tx_tdata  = w_tdata;
   assign axis.m_tx_tkeep  = w_tkeep;
   assign axis.m_tx_tvalid = w_tvalid;
   assign axis.m_tx_tlast  = w_tlast;
   assign axis.s_tx_tready = r_grant & {NUM_PORTS{axis.m_tx_tready}};
   assign grant            = r_grant;
   assign busy             = r_busy;
   // Flags the handshake of beat MAX_BEATS+1 itself; the counter saturates so it fires once per frame.
   assign oversize_error   = w_hs && (r_beat_cnt == c_CNT_LIMIT);

   always_ff @(posedge tx_clk or negedge tx_rst) begin
      if (!tx_rst) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_gidx     <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_any) begin
                  r_state    <= ST_PASS;
                  r_grant    <= c_ONE << w_sel;
                  r_gidx     <= w_sel;
                  r_busy     <= 1'b1;
                  r_beat_cnt <= '0;
               end
            end
            ST_PASS: begin
               if (w_hs && (r_beat_cnt != c_CNT_SAT)) begin
                  r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
               end
               if (w_hs && w_tlast) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
`ifdef TX_ARB_STRICT_PRIO_EN
                  if (r_gidx != '0) begin
                     r_rr_ptr <= w_next_ptr;
                  end
`else
                  r_rr_ptr <= w_next_ptr;
`endif
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tx_frame_arbiter                                          |
// | Description : Randomized bench for tx_frame_arbiter with a frame-level     |
// |               reference model (macro TX_ARB_STRICT_PRIO_EN honoured).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tx_frame_arbiter;
   localparam int NP   = 4;
   localparam int DW   = 32;
   localparam int DB   = DW/8;
   localparam int MAXB = 380;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NP-1:0] grant;
   logic          busy;
   logic          oversize_error;

   tx_frame_arbiter_if #(.NUM_PORTS(NP), .AXIS_DATA_WIDTH(DW), .AXIS_DATA_BYTES(DB)) axis ();

   tx_frame_arbiter #(
      .NUM_PORTS(NP), .AXIS_DATA_WIDTH(DW), .AXIS_DATA_BYTES(DB), .MAX_BEATS(MAXB)
   ) dut (
      .tx_clk(clk), .tx_rst(rst_n), .axis(axis),
      .grant(grant), .busy(busy), .oversize_error(oversize_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Source state: each port works through a queue of frame lengths.
   int            frames_q[NP][$];
   int            cur_len[NP];
   int            cur_beat[NP];
   bit            active[NP];
   bit            tv[NP];
   bit            hs_cap[NP];
   logic [DW-1:0] cur_data[NP];
   logic [DB-1:0] cur_keep[NP];
   int            valid_pct = 100;
   int            ready_mode = 0;
   int            rand_pct = 0;
   bit            tog = 1'b0;

   // Frame-level reference: pointer, granted port (-1 = none), beats in frame.
   int            m_ptr = 0;
   int            m_port = -1;
   int            m_cnt = 0;
   logic [NP-1:0] pred_grant = '0;
   bit            pred_valid = 1'b0;
   int            ovs_seen = 0;
   logic [NP-1:0] last_grant = '0;
   logic [NP-1:0] grant_log[$];

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int arb(input logic [NP-1:0] req, input int ptr);
`ifdef TX_ARB_STRICT_PRIO_EN
      if (req[0]) return 0;
      for (int k = 0; k < NP; k++) begin
         if (((ptr + k) % NP) != 0 && req[(ptr + k) % NP]) return (ptr + k) % NP;
      end
`else
      for (int k = 0; k < NP; k++) begin
         if (req[(ptr + k) % NP]) return (ptr + k) % NP;
      end
`endif
      return -1;
   endfunction

   function automatic bit is_last(input int p);
      return active[p] && (cur_beat[p] == cur_len[p] - 1);
   endfunction

   task automatic new_beat(input int p);
      cur_data[p] = $urandom;
      cur_keep[p] = is_last(p) ? DB'($urandom_range(1, (1 << DB) - 1)) : '1;
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         if (hs_cap[p]) begin
            cur_beat[p]++;
            tv[p] = 1'b0;
            if (cur_beat[p] >= cur_len[p]) active[p] = 1'b0;
            else new_beat(p);
         end
         hs_cap[p] = 1'b0;
         if (rand_pct > 0 && !active[p] && frames_q[p].size() == 0 &&
             $urandom_range(99) < rand_pct)
            frames_q[p].push_back($urandom_range(1, 8));
         if (!active[p] && frames_q[p].size() > 0) begin
            cur_len[p]  = frames_q[p].pop_front();
            cur_beat[p] = 0;
            active[p]   = 1'b1;
            new_beat(p);
         end
         if (active[p] && !tv[p]) tv[p] = ($urandom_range(99) < valid_pct);
         axis.s_tx_tdata[p*DW +: DW] = cur_data[p];
         axis.s_tx_tkeep[p*DB +: DB] = cur_keep[p];
         axis.s_tx_tvalid[p]         = tv[p];
         axis.s_tx_tlast[p]          = is_last(p);
      end
      case (ready_mode)
         0:       axis.m_tx_tready = 1'b1;
         1:       begin tog = ~tog; axis.m_tx_tready = tog; end
         default: axis.m_tx_tready = ($urandom_range(99) < 70);
      endcase
   endtask

   task automatic model_step();
      logic [NP-1:0] req;
      logic [NP-1:0] exp_rdy;
      int            nxt;
      bit            hs;
      req = axis.s_tx_tvalid;
      for (int p = 0; p < NP; p++) hs_cap[p] = axis.s_tx_tvalid[p] & axis.s_tx_tready[p];
      if (oversize_error) ovs_seen++;
      if (grant != '0 && last_grant == '0) grant_log.push_back(grant);
      last_grant = grant;
      if (pred_valid) chk_eq("grant", 64'(grant), 64'(pred_grant));
      nxt = m_port;
      if (m_port < 0) begin
         chk_eq("idle_m_tvalid", 64'(axis.m_tx_tvalid), 64'(0));
         chk_eq("idle_s_tready", 64'(axis.s_tx_tready), 64'(0));
         chk_eq("idle_busy", 64'(busy), 64'(0));
         chk_eq("idle_oversize", 64'(oversize_error), 64'(0));
         if (req != '0) begin
            nxt   = arb(req, m_ptr);
            m_cnt = 0;
         end
      end else begin
         exp_rdy = axis.m_tx_tready ? (NP'(1) << m_port) : '0;
         chk_eq("busy", 64'(busy), 64'(1));
         chk_eq("s_tready", 64'(axis.s_tx_tready), 64'(exp_rdy));
         chk_eq("m_tvalid", 64'(axis.m_tx_tvalid), 64'(req[m_port]));
         if (req[m_port]) begin
            chk_eq("m_tdata", 64'(axis.m_tx_tdata), 64'(cur_data[m_port]));
            chk_eq("m_tkeep", 64'(axis.m_tx_tkeep), 64'(cur_keep[m_port]));
            chk_eq("m_tlast", 64'(axis.m_tx_tlast), 64'(is_last(m_port)));
         end
         hs = req[m_port] && axis.m_tx_tready;
         chk_eq("oversize", 64'(oversize_error), 64'(hs && (m_cnt == MAXB)));
         if (hs) begin
            m_cnt++;
            if (is_last(m_port)) begin
`ifdef TX_ARB_STRICT_PRIO_EN
               if (m_port != 0) m_ptr = (m_port + 1) % NP;
`else
               m_ptr = (m_port + 1) % NP;
`endif
               nxt = -1;
            end
         end
      end
      m_port     = nxt;
      pred_grant = (nxt < 0) ? '0 : (NP'(1) << nxt);
      pred_valid = 1'b1;
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1 drive();
   endtask

   function automatic bit pending();
      bit any = (m_port >= 0);
      for (int p = 0; p < NP; p++) any |= active[p] || (frames_q[p].size() > 0);
      return any;
   endfunction

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while (pending() && n < budget) begin
         cycle();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s timeout after %0d cycles", tag, n);
      end
      cycle();
   endtask

   task automatic reset_dut();
      rst_n    = 1'b0;
      rand_pct = 0;
      for (int p = 0; p < NP; p++) begin
         frames_q[p].delete();
         active[p] = 1'b0;
         tv[p]     = 1'b0;
         hs_cap[p] = 1'b0;
      end
      drive();
      m_port = -1; m_ptr = 0; m_cnt = 0;
      pred_grant = '0; pred_valid = 1'b1; last_grant = '0;
      grant_log.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic chk_log(input string tag, input int n, input int first, input int step);
      chk_eq({tag, "_count"}, 64'(grant_log.size()), 64'(n));
      for (int i = 0; i < n && i < grant_log.size(); i++)
         chk_eq(tag, 64'(grant_log[i]), 64'(NP'(1) << ((first + i * step) % NP)));
   endtask

   initial begin
      int n;
      for (int p = 0; p < NP; p++) begin
         cur_data[p] = '0;
         cur_keep[p] = '0;
      end
      axis.s_tx_tdata  = '0;
      axis.s_tx_tkeep  = '0;
      axis.s_tx_tvalid = '1;
      axis.s_tx_tlast  = '0;
      axis.m_tx_tready = 1'b1;
      #12;
      chk_eq("rst_grant", 64'(grant), 64'(0));
      chk_eq("rst_busy", 64'(busy), 64'(0));
      chk_eq("rst_oversize", 64'(oversize_error), 64'(0));
      chk_eq("rst_m_tvalid", 64'(axis.m_tx_tvalid), 64'(0));
      chk_eq("rst_s_tready", 64'(axis.s_tx_tready), 64'(0));
      reset_dut();

      // Port 2 alone, then ports 0 and 3 together: pointer must now favour 3.
      frames_q[2].push_back(3);
      drain(50, "p2_frame");
      frames_q[0].push_back(2);
      frames_q[3].push_back(2);
      drain(50, "after_p2");
      chk_log("p2_then_3_0", 3, 2, 1);

      // All ports busy: strict rotation 0,1,2,3,0,...
      reset_dut();
      for (int p = 0; p < NP; p++) begin
         frames_q[p].push_back(2);
         frames_q[p].push_back(2);
      end
      drain(200, "all_ports");
`ifndef TX_ARB_STRICT_PRIO_EN
      chk_log("rr_order", 8, 0, 1);
`endif

      // MAC backpressure toggling while port 1 streams.
      ready_mode = 1;
      frames_q[1].push_back(4);
      drain(100, "toggle_ready");
      ready_mode = 0;

      // Oversize: 381 beats pulse once; the following short frame does not.
      ovs_seen = 0;
      frames_q[0].push_back(MAXB + 1);
      frames_q[0].push_back(2);
      drain(1000, "oversize");
      chk_eq("oversize_pulses", 64'(ovs_seen), 64'(1));

      // Asynchronous reset in the middle of a port-3 frame.
      frames_q[3].push_back(10);
      n = 0;
      while (cur_beat[3] < 5 && n < 100) begin
         cycle();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL midframe_wait timeout after %0d cycles", n);
      end
      #2 rst_n = 1'b0;
      #1;
      chk_eq("async_grant", 64'(grant), 64'(0));
      chk_eq("async_busy", 64'(busy), 64'(0));
      chk_eq("async_m_tvalid", 64'(axis.m_tx_tvalid), 64'(0));
      chk_eq("async_s_tready", 64'(axis.s_tx_tready), 64'(0));
      chk_eq("async_oversize", 64'(oversize_error), 64'(0));
      reset_dut();
      frames_q[1].push_back(2);
      frames_q[3].push_back(2);
      drain(50, "post_reset");
      chk_log("post_reset", 2, 1, 2);

`ifdef TX_ARB_STRICT_PRIO_EN
      reset_dut();
      frames_q[0].push_back(2);
      frames_q[0].push_back(1);
      frames_q[0].push_back(3);
      frames_q[2].push_back(2);
      drain(100, "strict_prio");
      chk_eq("strict_count", 64'(grant_log.size()), 64'(4));
      for (int i = 0; i < 3 && i < grant_log.size(); i++)
         chk_eq("strict_p0", 64'(grant_log[i]), 64'(1));
      if (grant_log.size() > 3) chk_eq("strict_p2", 64'(grant_log[3]), 64'(4));
`endif

      // Randomized traffic with stalls on both sides.
      reset_dut();
      rand_pct   = 4;
      valid_pct  = 70;
      ready_mode = 2;
      repeat (2000) cycle();
      rand_pct = 0;
      drain(500, "random_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
